// File: rtl/dsp_result_drain.sv
// dsp_result_drain
//   Read-side companion to a clock-enabled DSP48A1 register chain. A valid
//   token travels beside the operands through LATENCY CE-gated stages. When
//   the token reaches the last stage, the P result is written into a small
//   FIFO, which drains over a valid/ready stream. The shared pipeline
//   clock-enable is dropped only when a valid result would otherwise land in
//   a full FIFO.
//
// Optional feature: define DSP_DRAIN_STATS_EN to add the stall_cycles and
//   push_count statistics outputs.
//
// Ports
//   clk           rising-edge clock for all state
//   rst           synchronous reset, active low
//   in_valid      operands entering the pipeline this cycle are a real operation
//   p_in          P output of the DSP pipeline
//   ce_out        clock-enable for every DSP pipeline stage
//   out_data      head-of-FIFO result, 0 when out_valid is low
//   out_valid     out_data holds a result
//   out_ready     consumer accepts out_data this cycle
//   count         FIFO occupancy
//   stall_cycles  (stats) cycles out of reset with ce_out low, saturating
//   push_count    (stats) number of captured results, wrapping
module dsp_result_drain #(
    parameter int WIDTH   = 48,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           p_in,
    output logic                       ce_out,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DSP_DRAIN_STATS_EN
    ,
    output logic [15:0]                stall_cycles,
    output logic [15:0]                push_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [LATENCY-1:0] tok;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               tok_end;
    logic               full;
    logic               push;
    logic               pop;

    assign tok_end = tok[LATENCY-1];
    assign full    = (count == CNT_W'(DEPTH));

    // Stall only when a real result is waiting and there is nowhere to put
    // it. Depends on registered state and rst only, never on out_ready, so a
    // pop in a full cycle still costs one bubble before the pipe resumes.
    assign ce_out    = rst & ~(full & tok_end);
    assign push      = ce_out & tok_end;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tok    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // The cast keeps the low LATENCY bits, which also covers LATENCY=1.
            if (ce_out) begin
                tok <= LATENCY'({tok, in_valid});
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= p_in;
        end
    end

`ifdef DSP_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            push_count   <= '0;
        end else begin
            if (!ce_out && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (push) begin
                push_count <= push_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_result_drain.sv
// Bench for dsp_result_drain. A behavioural DSP pipeline (LATENCY CE-gated
// data stages) feeds p_in so results line up with their tokens.
module tb_dsp_result_drain;

    localparam int WIDTH   = 48;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] p_in;
    logic             ce_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [2:0]       count;
`ifdef DSP_DRAIN_STATS_EN
    logic [15:0]      stall_cycles;
    logic [15:0]      push_count;
`endif

    logic [LATENCY-1:0][WIDTH-1:0] dp = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce_out) dp <= {dp[LATENCY-2:0], in_data};
    end
    assign p_in = dp[LATENCY-1];

    dsp_result_drain #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .p_in(p_in),
        .ce_out(ce_out),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count)
`ifdef DSP_DRAIN_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .push_count(push_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        checks++;
        if (ce_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ce_low got %b exp 0", ce_out);
        end
        tick();
        tick();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", count);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (ce_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ce got %b exp 1", ce_out);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid %b data %h exp 0/0", out_valid, out_data);
        end
        // in_valid held high during reset must not have produced tokens
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL reset_no_token c=%0d got valid %b count %0d exp 0/0", c, out_valid, count);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            in_valid = (c == 0);
            in_data = (c == 0) ? 48'h0000_1234_5678 : 48'h0000_0000_DEAD;
            out_ready = 1'b1;
            #1;
            checks++;
            if (ce_out !== 1'b1) begin
                errors++;
                $display("FAIL single_ce c=%0d got %b exp 1", c, ce_out);
            end
            checks++;
            if (out_valid !== (c == 5) || count !== ((c == 5) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL single_valid c=%0d got valid %b count %0d exp %b", c, out_valid, count, (c == 5));
            end
            checks++;
            if (out_data !== ((c == 5) ? 48'h0000_1234_5678 : 48'h0)) begin
                errors++;
                $display("FAIL single_data c=%0d got %h", c, out_data);
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        logic ev;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            in_data = WIDTH'(c + 4);
            out_ready = 1'b1;
            #1;
            ev = (c >= 5 && c <= 12);
            checks++;
            if (ce_out !== 1'b1) begin
                errors++;
                $display("FAIL stream_ce c=%0d got %b exp 1", c, ce_out);
            end
            checks++;
            if (out_valid !== ev || count !== (ev ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL stream_valid c=%0d got valid %b count %0d exp %b", c, out_valid, count, ev);
            end
            if (ev) begin
                checks++;
                if (out_data !== WIDTH'(c - 1)) begin
                    errors++;
                    $display("FAIL stream_data c=%0d got %0d exp %0d", c, out_data, c - 1);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int got;
        int stalls;
        int cyc;
        logic acc;
        do_reset();
        sent = 0;
        got = 0;
        stalls = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = 1'b0;
            in_valid = (sent < 10);
            in_data = WIDTH'(100 + sent);
            #1;
            checks++;
            if (ce_out !== (c < 8)) begin
                errors++;
                $display("FAIL bp_ce c=%0d got %b exp %b", c, ce_out, (c < 8));
            end
            if (c == 8) begin
                checks++;
                if (count !== 3'd4) begin
                    errors++;
                    $display("FAIL bp_full c=%0d got %0d exp 4", c, count);
                end
            end
            if (c == 11) begin
                checks++;
                if (out_data !== WIDTH'(100)) begin
                    errors++;
                    $display("FAIL bp_head got %0d exp 100", out_data);
                end
            end
            if (!ce_out) stalls++;
            acc = ce_out && in_valid;
            tick();
            if (acc) sent++;
        end
        checks++;
        if (sent != 8) begin
            errors++;
            $display("FAIL bp_accepted got %0d exp 8", sent);
        end
        cyc = 12;
        while (got < 10 && cyc < 72) begin
            out_ready = 1'b1;
            in_valid = (sent < 10);
            in_data = WIDTH'(100 + sent);
            #1;
            if (cyc == 12 || cyc == 13) begin
                checks++;
                if (ce_out !== (cyc == 13)) begin
                    errors++;
                    $display("FAIL bp_resume cyc=%0d got %b exp %b", cyc, ce_out, (cyc == 13));
                end
            end
            if (!ce_out) stalls++;
            if (out_valid) begin
                checks++;
                if (out_data !== WIDTH'(100 + got)) begin
                    errors++;
                    $display("FAIL bp_order idx=%0d got %0d exp %0d", got, out_data, 100 + got);
                end
                got++;
            end
            acc = ce_out && in_valid;
            tick();
            if (acc) sent++;
            cyc++;
        end
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL bp_total got %0d exp 10", got);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL bp_no_dup c=%0d got valid %b count %0d exp 0/0", c, out_valid, count);
            end
            tick();
        end
        checks++;
        if (stalls != 5) begin
            errors++;
            $display("FAIL bp_stall_cycles got %0d exp 5", stalls);
        end
`ifdef DSP_DRAIN_STATS_EN
        checks++;
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL stats_stall got %0d exp 5", stall_cycles);
        end
        checks++;
        if (push_count !== 16'd10) begin
            errors++;
            $display("FAIL stats_push got %0d exp 10", push_count);
        end
`endif
    endtask

    task automatic test_bubbles();
        logic [WIDTH-1:0] expv [6];
        int got;
        int cyc;
        expv[0] = 48'd200;
        expv[1] = 48'd201;
        expv[2] = 48'd202;
        expv[3] = 48'd203;
        expv[4] = 48'd210;
        expv[5] = 48'd213;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            out_ready = 1'b0;
            in_valid = (c < 4) || (c == 10) || (c == 13);
            in_data = WIDTH'(200 + c);
            #1;
            if (c == 8) begin
                checks++;
                if (count !== 3'd4) begin
                    errors++;
                    $display("FAIL bub_full got %0d exp 4", count);
                end
            end
            if (c >= 9) begin
                checks++;
                if (ce_out !== (c <= 13)) begin
                    errors++;
                    $display("FAIL bub_ce c=%0d got %b exp %b", c, ce_out, (c <= 13));
                end
            end
            tick();
        end
        got = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (got < 6 && cyc < 40) begin
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++;
                if (out_data !== expv[got]) begin
                    errors++;
                    $display("FAIL bub_order idx=%0d got %0d exp %0d", got, out_data, expv[got]);
                end
                got++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (got != 6 || count !== 3'd0) begin
            errors++;
            $display("FAIL bub_total got %0d count %0d exp 6/0", got, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            out_ready = 1'b0;
            in_valid = (c < 3) || (c == 4) || (c == 5);
            in_data = WIDTH'(300 + c);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre_count got %0d exp 3", count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ce_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_ce_in_reset got %b exp 0", ce_out);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || count !== 3'd0 || ce_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_after got valid %b data %h count %0d ce %b exp 0/0/0/1",
                     out_valid, out_data, count, ce_out);
        end
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_flushed c=%0d got %b exp 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
